// File: rtl/bit_sum_frame_acc_if.sv
// bit_sum_frame_acc_if: popcount-sum input stream and frame-result output stream; thresh/out_over exist under BIT_SUM_FRAME_ACC_THRESH_EN
interface bit_sum_frame_acc_if #(
  parameter int DATA_W    = 8,
  parameter int MAX_WORDS = 16,
  parameter int POS_W     = $clog2(DATA_W),
  parameter int CNT_W     = $clog2(MAX_WORDS + 1),
  parameter int ACC_W     = $clog2(DATA_W * MAX_WORDS + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [POS_W:0]   in_sum;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_words;
  logic             out_forced;
`ifdef BIT_SUM_FRAME_ACC_THRESH_EN
  logic [ACC_W-1:0] thresh;
  logic             out_over;
`endif
  modport master (
    output in_valid, in_sum, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_words, out_forced
`ifdef BIT_SUM_FRAME_ACC_THRESH_EN
    , output thresh, input out_over
`endif
  );
  modport slave (
    input  in_valid, in_sum, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_words, out_forced
`ifdef BIT_SUM_FRAME_ACC_THRESH_EN
    , input thresh, output out_over
`endif
  );
endinterface

// File: rtl/bit_sum_frame_acc.sv
// bit_sum_frame_acc: accumulates per-word popcount sums into frame totals; optional threshold flag via BIT_SUM_FRAME_ACC_THRESH_EN
module bit_sum_frame_acc #(
  parameter int DATA_W    = 8,
  parameter int MAX_WORDS = 16,
  parameter int POS_W     = $clog2(DATA_W),
  parameter int CNT_W     = $clog2(MAX_WORDS + 1),
  parameter int ACC_W     = $clog2(DATA_W * MAX_WORDS + 1)
) (
  input logic clk,
  input logic rst_n,
  bit_sum_frame_acc_if.slave s
);
  typedef enum logic {ACC, DONE} state_t;
  state_t state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] total;
  logic accept, last_cnt, close;
  assign s.out_valid = state == DONE;
  assign s.in_ready  = !s.out_valid || s.out_ready;
  assign accept      = s.in_valid && s.in_ready;
  assign last_cnt    = cnt == CNT_W'(MAX_WORDS - 1);
  assign close       = accept && (s.in_last || last_cnt);
  assign total       = acc + ACC_W'(s.in_sum);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACC;
      acc          <= '0;
      cnt          <= '0;
      s.out_sum    <= '0;
      s.out_words  <= '0;
      s.out_forced <= 1'b0;
`ifdef BIT_SUM_FRAME_ACC_THRESH_EN
      s.out_over   <= 1'b0;
`endif
    end else if (close) begin
      state        <= DONE;
      acc          <= '0;
      cnt          <= '0;
      s.out_sum    <= total;
      s.out_words  <= cnt + CNT_W'(1);
      s.out_forced <= !s.in_last && last_cnt;
`ifdef BIT_SUM_FRAME_ACC_THRESH_EN
      s.out_over   <= total >= s.thresh;
`endif
    end else begin
      if (accept) begin
        acc <= total;
        cnt <= cnt + CNT_W'(1);
      end
      if (state == DONE && s.out_ready) state <= ACC;
    end
  end
endmodule

// File: tb/tb_bit_sum_frame_acc.sv
// tb_bit_sum_frame_acc: vector table, corner sequences and random traffic against a frame-level model
module tb_bit_sum_frame_acc;
  localparam int DATA_W = 8, MAX_WORDS = 16, POS_W = 3, CNT_W = 5, ACC_W = 8;
  logic clk = 0, rst_n;
  always #5 clk = ~clk;
  bit_sum_frame_acc_if #(.DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS)) bus();
  bit_sum_frame_acc #(.DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS)) dut (.clk(clk), .rst_n(rst_n), .s(bus));
  int total = 0, bad = 0;
  int frame[$];
  bit m_valid, m_forced, m_over;
  int m_sum, m_words;
  typedef struct {bit v; int s; bit l; bit r; bit er; bit ev; int es; int ew; bit ef;} vec_t;
  vec_t tbl[16];
  logic rdy;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
    end
  endtask
  task automatic model_clear();
    frame.delete();
    m_valid = 0; m_forced = 0; m_over = 0; m_sum = 0; m_words = 0;
  endtask
  task automatic cycle(bit v, int sm, bit l, bit r, int th, output logic rd);
    bit er, closed;
    bus.in_valid = v; bus.in_sum = sm[POS_W:0]; bus.in_last = l; bus.out_ready = r;
`ifdef BIT_SUM_FRAME_ACC_THRESH_EN
    bus.thresh = th[ACC_W-1:0];
`endif
    #3;
    er = !m_valid || r;
    rd = bus.in_ready;
    chk("in_ready", bus.in_ready, er);
    @(posedge clk);
    closed = 0;
    if (v && er) begin
      frame.push_back(sm);
      if (l || frame.size() == MAX_WORDS) begin
        m_sum = 0;
        foreach (frame[i]) m_sum += frame[i];
        m_words = frame.size();
        m_forced = !l && frame.size() == MAX_WORDS;
        m_over = m_sum >= th;
        m_valid = 1;
        closed = 1;
        frame.delete();
      end
    end
    if (!closed && r) m_valid = 0;
    #1;
    chk("out_valid", bus.out_valid, m_valid);
    chk("out_sum", bus.out_sum, m_sum);
    chk("out_words", bus.out_words, m_words);
    chk("out_forced", bus.out_forced, m_forced);
`ifdef BIT_SUM_FRAME_ACC_THRESH_EN
    chk("out_over", bus.out_over, m_over);
`endif
  endtask
  task automatic chk_zero(string n);
    chk({n, "_valid"}, bus.out_valid, 0);
    chk({n, "_sum"}, bus.out_sum, 0);
    chk({n, "_words"}, bus.out_words, 0);
    chk({n, "_forced"}, bus.out_forced, 0);
    chk({n, "_ready"}, bus.in_ready, 1);
`ifdef BIT_SUM_FRAME_ACC_THRESH_EN
    chk({n, "_over"}, bus.out_over, 0);
`endif
  endtask
  initial begin
    tbl[0]  = '{1, 3, 0, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 5, 0, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 8, 1, 1, 1, 1, 16, 3, 0};
    tbl[3]  = '{0, 0, 0, 1, 1, 0, 16, 3, 0};
    tbl[4]  = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    tbl[5]  = '{1, 2, 1, 1, 1, 1, 2, 1, 0};
    tbl[6]  = '{1, 3, 1, 1, 1, 1, 3, 1, 0};
    tbl[7]  = '{0, 0, 0, 1, 1, 0, 3, 1, 0};
    tbl[8]  = '{1, 4, 1, 0, 1, 1, 4, 1, 0};
    for (int i = 9; i < 14; i++) tbl[i] = '{1, 7, 1, 0, 0, 1, 4, 1, 0};
    tbl[14] = '{1, 7, 1, 1, 1, 1, 7, 1, 0};
    tbl[15] = '{0, 0, 0, 1, 1, 0, 7, 1, 0};
    rst_n = 0;
    bus.in_valid = 0; bus.in_sum = 0; bus.in_last = 0; bus.out_ready = 1;
`ifdef BIT_SUM_FRAME_ACC_THRESH_EN
    bus.thresh = 0;
`endif
    model_clear();
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    #2 rst_n = 1;
    @(posedge clk); #1;
    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].s, tbl[i].l, tbl[i].r, 0, rdy);
      chk($sformatf("tbl%0d_ready", i), rdy, tbl[i].er);
      chk($sformatf("tbl%0d_valid", i), bus.out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_sum", i), bus.out_sum, tbl[i].es);
      chk($sformatf("tbl%0d_words", i), bus.out_words, tbl[i].ew);
      chk($sformatf("tbl%0d_forced", i), bus.out_forced, tbl[i].ef);
    end
    for (int i = 0; i < 16; i++) cycle(1, 8, 0, 1, 0, rdy);
    chk("forced_valid", bus.out_valid, 1);
    chk("forced_sum", bus.out_sum, 128);
    chk("forced_words", bus.out_words, 16);
    chk("forced_flag", bus.out_forced, 1);
    cycle(1, 2, 1, 1, 0, rdy);
    chk("after_forced_sum", bus.out_sum, 2);
    chk("after_forced_words", bus.out_words, 1);
    chk("after_forced_flag", bus.out_forced, 0);
    cycle(0, 0, 0, 1, 0, rdy);
    cycle(1, 4, 0, 1, 0, rdy);
    cycle(1, 4, 0, 1, 0, rdy);
    bus.in_valid = 0;
    rst_n = 0;
    #2 chk_zero("midreset");
    model_clear();
    @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
    cycle(1, 1, 0, 1, 0, rdy);
    cycle(1, 1, 1, 1, 0, rdy);
    chk("postreset_sum", bus.out_sum, 2);
    chk("postreset_words", bus.out_words, 2);
`ifdef BIT_SUM_FRAME_ACC_THRESH_EN
    cycle(1, 3, 0, 1, 10, rdy);
    cycle(1, 5, 0, 1, 10, rdy);
    cycle(1, 2, 1, 1, 10, rdy);
    chk("thresh_over_hi", bus.out_over, 1);
    cycle(1, 3, 0, 1, 10, rdy);
    cycle(1, 5, 0, 1, 10, rdy);
    cycle(1, 1, 1, 1, 10, rdy);
    chk("thresh_over_lo", bus.out_over, 0);
`endif
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(3) != 0, $urandom_range(DATA_W), $urandom_range(5) == 0,
            $urandom_range(9) < 7, $urandom_range(DATA_W * MAX_WORDS), rdy);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
